// File: rtl/daq_pkg.sv
// Shared types and defaults for the DAQ SRAM writer slice.
package daq_pkg;

  localparam int DAQ_DW        = 32;
  localparam int DAQ_REGION_AW = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WRITE = 2'd2
  } daq_state_e;

  // Index width for a channel count; never narrower than one bit.
  function automatic int daq_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/daq_sram_writer_if.sv
// Write-only SRAM port between the DAQ writer (master) and the memory controller (slave).
interface daq_sram_writer_if
  import daq_pkg::*;
#(
  parameter int addr_w = 12,
  parameter int data_w = DAQ_DW
);

  logic [addr_w-1:0] sram_addr;
  logic [data_w-1:0] sram_data;
  logic              sram_we;
  logic              sram_ack;

  modport master (output sram_addr, output sram_data, output sram_we, input sram_ack);
  modport slave  (input sram_addr, input sram_data, input sram_we, output sram_ack);

endinterface

// File: rtl/daq_rr_arbiter.sv
// Combinational round-robin pick: first requester searching upward from last+1, wrapping.
module daq_rr_arbiter
  import daq_pkg::*;
#(
  parameter int  channels = 4,
  localparam int cw       = daq_idx_w(channels)
) (
  input  logic [channels-1:0] req,
  input  logic [cw-1:0]       last,
  output logic [channels-1:0] sel,
  output logic [cw-1:0]       sel_idx,
  output logic                any
);

  logic [cw-1:0] cand;

  // channels is a power of two, so the index adder wraps for free.
  always_comb begin
    sel     = '0;
    sel_idx = '0;
    any     = 1'b0;
    cand    = last;
    for (int i = 1; i <= channels; i++) begin
      cand = last + cw'(i);
      if (!any && req[cand]) begin
        any       = 1'b1;
        sel_idx   = cand;
        sel[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/daq_sram_writer.sv
// Grants DAQ channels round-robin and writes each word into the channel's circular SRAM region.
// Define DAQ_SRAM_WRAP_FLAG_EN to build sticky per-channel wrap flags, clear_flags handling and irq.
module daq_sram_writer
  import daq_pkg::*;
#(
  parameter int  channels  = 4,
  parameter int  dw        = DAQ_DW,
  parameter int  region_aw = DAQ_REGION_AW,
  localparam int cw        = daq_idx_w(channels),
  localparam int aw        = cw + region_aw
) (
  input  logic                   wb_clk,
  input  logic                   wb_rst_n,
  input  logic [channels-1:0]    start_sram,
  input  logic [channels*dw-1:0] data_in,
  output logic [channels-1:0]    grant,
  daq_sram_writer_if.master      sram,
  input  logic [channels-1:0]    clear_flags,
  output logic [channels-1:0]    wrap_flag,
  output logic                   irq
);

  daq_state_e state_q, state_d;
  logic [cw-1:0]       ch_q, ch_d;
  logic [cw-1:0]       last_q, last_d;
  logic [channels-1:0] sel_q, sel_d;
  logic [aw-1:0]       addr_q, addr_d;
  logic [dw-1:0]       data_q, data_d;
  logic                we_q, we_d;

  logic [channels-1:0]                ptr_adv;
  logic [channels-1:0]                wrap_ev;
  logic [channels-1:0][region_aw-1:0] ptr_vec;

  logic [channels-1:0] arb_sel;
  logic [cw-1:0]       arb_idx;
  logic                arb_any;

  daq_rr_arbiter #(.channels(channels)) u_arb (
    .req     (start_sram),
    .last    (last_q),
    .sel     (arb_sel),
    .sel_idx (arb_idx),
    .any     (arb_any)
  );

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    last_d  = last_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = we_q;
    ptr_adv = '0;
    grant   = '0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          ch_d    = arb_idx;
          sel_d   = arb_sel;
          state_d = GRANT;
        end
      end
      GRANT: begin
        grant   = sel_q;
        data_d  = data_in[int'(ch_q)*dw +: dw];
        addr_d  = {ch_q, ptr_vec[ch_q]};
        we_d    = 1'b1;
        state_d = WRITE;
      end
      WRITE: begin
        // Address/data stay frozen in their registers until the controller accepts.
        if (sram.sram_ack) begin
          we_d          = 1'b0;
          last_d        = ch_q;
          ptr_adv[ch_q] = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      last_q  <= cw'(channels - 1);
      sel_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
    end
  end

  assign sram.sram_addr = addr_q;
  assign sram.sram_data = data_q;
  assign sram.sram_we   = we_q;

  for (genvar gi = 0; gi < channels; gi++) begin : g_ch
    logic [region_aw-1:0] ptr_q, ptr_d;

    always_comb begin
      ptr_d = ptr_q;
      if (ptr_adv[gi]) ptr_d = ptr_q + region_aw'(1);
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) ptr_q <= '0;
      else           ptr_q <= ptr_d;
    end

    assign ptr_vec[gi] = ptr_q;
    assign wrap_ev[gi] = ptr_adv[gi] & (&ptr_q);

`ifdef DAQ_SRAM_WRAP_FLAG_EN
    logic flag_q, flag_d;

    // A wrap in the same cycle as a clear keeps the flag set.
    always_comb flag_d = (flag_q & ~clear_flags[gi]) | wrap_ev[gi];

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) flag_q <= 1'b0;
      else           flag_q <= flag_d;
    end

    assign wrap_flag[gi] = flag_q;
`else
    logic unused_flag_inputs;
    assign unused_flag_inputs = wrap_ev[gi] ^ clear_flags[gi];
    assign wrap_flag[gi]      = 1'b0;
`endif
  end

  assign irq = |wrap_flag;

endmodule

// File: tb/tb_daq_sram_writer.sv
// Randomised bench for daq_sram_writer with a transaction-level reference model.
// Honours DAQ_SRAM_WRAP_FLAG_EN when forming wrap_flag/irq expectations.
module tb_daq_sram_writer;
  import daq_pkg::*;

  localparam int CH  = 4;
  localparam int DW  = 32;
  localparam int RAW = 10;
  localparam int CW  = 2;
  localparam int AW  = CW + RAW;
  localparam int RW  = 1 << RAW;

  logic              wb_clk = 1'b0;
  logic              wb_rst_n;
  logic [CH-1:0]     start_sram;
  logic [CH*DW-1:0]  data_in;
  logic [CH-1:0]     grant;
  logic [CH-1:0]     clear_flags;
  logic [CH-1:0]     wrap_flag;
  logic              irq;

  daq_sram_writer_if #(.addr_w(AW), .data_w(DW)) sram_bus ();

  always #5 wb_clk = ~wb_clk;

  daq_sram_writer #(.channels(CH), .dw(DW), .region_aw(RAW)) dut (
    .wb_clk      (wb_clk),
    .wb_rst_n    (wb_rst_n),
    .start_sram  (start_sram),
    .data_in     (data_in),
    .grant       (grant),
    .sram        (sram_bus),
    .clear_flags (clear_flags),
    .wrap_flag   (wrap_flag),
    .irq         (irq)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: phase 0 idle, 1 granting, 2 writing.
  int            m_phase, m_ch, m_last, ack_wait;
  int            mptr [CH];
  int            n_wr_ch [CH];
  logic [CH-1:0] mflag;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  // Stimulus state.
  logic [CH-1:0] drv_req, rel_pend, drv_clr, chan_en;
  logic [DW-1:0] drv_word [CH];
  logic          drv_ack;
  int            req_prob, ack_mode, clr_prob;
  bit            withdraw_en, clr_on_wrap;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [CH-1:0] req, input int last);
    for (int i = 1; i <= CH; i++)
      if (req[(last + i) % CH]) return (last + i) % CH;
    return 0;
  endfunction

  task automatic apply_inputs();
    start_sram = drv_req;
    for (int k = 0; k < CH; k++) data_in[k*DW +: DW] = drv_word[k];
    sram_bus.sram_ack = drv_ack;
    clear_flags = drv_clr;
  endtask

  task automatic reset_model();
    m_phase = 0; m_ch = 0; m_last = CH - 1; ack_wait = 0;
    mflag = '0; m_addr = '0; m_data = '0;
    for (int k = 0; k < CH; k++) begin
      mptr[k] = 0; drv_word[k] = '0;
    end
    drv_req = '0; rel_pend = '0; drv_clr = '0; drv_ack = 1'b0;
  endtask

  task automatic step_cycle();
    logic [CH-1:0] wrap_ev, exp_grant, exp_flag;
    @(negedge wb_clk);
    wrap_ev = '0;
    case (m_phase)
      0: if (drv_req != '0) begin
        m_ch = rr_pick(drv_req, m_last);
        m_phase = 1;
      end
      1: begin
        m_addr = AW'(m_ch * RW + mptr[m_ch]);
        m_data = drv_word[m_ch];
        m_phase = 2;
        ack_wait = 0;
      end
      default: if (drv_ack) begin
        $display("write ch%0d addr 0x%03h data 0x%08h", m_ch, m_addr, m_data);
        n_wr_ch[m_ch]++;
        if (mptr[m_ch] == RW - 1) wrap_ev[m_ch] = 1'b1;
        mptr[m_ch] = (mptr[m_ch] + 1) % RW;
        m_last = m_ch;
        m_phase = 0;
      end else ack_wait++;
    endcase
    mflag = (mflag & ~drv_clr) | wrap_ev;

    exp_grant = (m_phase == 1) ? CH'(1 << m_ch) : '0;
    check_eq("grant", grant, exp_grant);
    check_eq("sram_we", sram_bus.sram_we, m_phase == 2);
    if (m_phase == 2) begin
      check_eq("sram_addr", sram_bus.sram_addr, m_addr);
      check_eq("sram_data", sram_bus.sram_data, m_data);
    end
`ifdef DAQ_SRAM_WRAP_FLAG_EN
    exp_flag = mflag;
`else
    exp_flag = '0;
`endif
    check_eq("wrap_flag", wrap_flag, exp_flag);
    check_eq("irq", irq, |exp_flag);

    // Granted channel holds through its grant cycle and drops afterwards.
    drv_req &= ~rel_pend;
    rel_pend = exp_grant;
    for (int k = 0; k < CH; k++) begin
      if (!drv_req[k]) begin
        drv_word[k] = $urandom;
        if (chan_en[k] && ($urandom_range(99) < req_prob)) drv_req[k] = 1'b1;
      end else if (withdraw_en && !exp_grant[k] && ($urandom_range(31) == 0)) begin
        drv_req[k] = 1'b0;
      end
    end
    case (ack_mode)
      0:       drv_ack = ($urandom_range(2) == 0);
      1:       drv_ack = 1'b1;
      default: drv_ack = (m_phase == 2) && (ack_wait >= 4);
    endcase
    drv_clr = '0;
    for (int k = 0; k < CH; k++)
      if ($urandom_range(99) < clr_prob) drv_clr[k] = 1'b1;
    if (clr_on_wrap && m_phase == 2 && drv_ack && mptr[m_ch] == RW - 1) drv_clr[m_ch] = 1'b1;
    apply_inputs();
  endtask

  initial begin
    int start_cnt;
    bit hit;
    wb_rst_n = 1'b0;
    for (int k = 0; k < CH; k++) n_wr_ch[k] = 0;
    reset_model();
    chan_en = '0; req_prob = 0; ack_mode = 1; clr_prob = 0;
    withdraw_en = 1'b0; clr_on_wrap = 1'b0;
    data_in = '0;
    apply_inputs();
    repeat (3) @(negedge wb_clk);
    check_eq("rst_grant", grant, 0);
    check_eq("rst_we", sram_bus.sram_we, 0);
    check_eq("rst_addr", sram_bus.sram_addr, 0);
    check_eq("rst_data", sram_bus.sram_data, 0);
    check_eq("rst_wrap_flag", wrap_flag, 0);
    check_eq("rst_irq", irq, 0);

    // Single request from channel 2 with immediate ack.
    drv_req[2] = 1'b1; drv_word[2] = 32'hDEADBEEF;
    apply_inputs();
    wb_rst_n = 1'b1;
    step_cycle();
    check_eq("t1_grant", grant, 4'b0100);
    step_cycle();
    check_eq("t1_we", sram_bus.sram_we, 1);
    check_eq("t1_addr", sram_bus.sram_addr, 12'h800);
    check_eq("t1_data", sram_bus.sram_data, 32'hDEADBEEF);
    repeat (2) step_cycle();
    drv_req[2] = 1'b1; drv_word[2] = 32'h12345678;
    apply_inputs();
    repeat (2) step_cycle();
    check_eq("t1_ptr_advanced", sram_bus.sram_addr, 12'h801);
    repeat (3) step_cycle();

    // All channels requesting continuously.
    chan_en = 4'hF; req_prob = 100; ack_mode = 1;
    repeat (60) step_cycle();

    // Ack delayed by several cycles.
    ack_mode = 2;
    repeat (80) step_cycle();

    // Channel 1 alone streams past two region wraps, with clears sprinkled in.
    chan_en = 4'b0010; ack_mode = 1; clr_prob = 5; clr_on_wrap = 1'b1;
    start_cnt = n_wr_ch[1];
    for (int c = 0; c < 7500 && (n_wr_ch[1] - start_cnt) < 2100; c++) step_cycle();
    check_eq("ch1_stream_done", (n_wr_ch[1] - start_cnt) >= 2100, 1);

    // Mixed random traffic, random acks (also outside WRITE), withdrawals.
    chan_en = 4'hF; req_prob = 30; ack_mode = 0; clr_prob = 3;
    withdraw_en = 1'b1; clr_on_wrap = 1'b0;
    repeat (3000) step_cycle();

    // Reset asserted during WRITE.
    req_prob = 100; ack_mode = 2; withdraw_en = 1'b0; clr_prob = 0;
    hit = 1'b0;
    for (int c = 0; c < 60 && !hit; c++) begin
      step_cycle();
      if (m_phase == 2) hit = 1'b1;
    end
    check_eq("reach_write", hit, 1);
    #2 wb_rst_n = 1'b0;
    #1;
    check_eq("rst_mid_we", sram_bus.sram_we, 0);
    check_eq("rst_mid_grant", grant, 0);
    reset_model();
    chan_en = '0; req_prob = 0; ack_mode = 1;
    apply_inputs();
    repeat (2) @(negedge wb_clk);
    check_eq("rst_mid_flags", wrap_flag, 0);
    drv_req = 4'b1010; drv_word[1] = 32'hA5A5_0001; drv_word[3] = 32'h5A5A_0003;
    apply_inputs();
    wb_rst_n = 1'b1;
    step_cycle();
    check_eq("rst_first_grant", grant, 4'b0010);
    step_cycle();
    check_eq("rst_ptr1_zero", sram_bus.sram_addr, 12'h400);
    repeat (3) step_cycle();
    check_eq("rst_ptr3_zero", sram_bus.sram_addr, 12'hC00);
    repeat (5) step_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
